// File: rtl/tcam_enc_pkg.sv
// Shared types and derived-width helper for the TCAM match-line encoder.
package tcam_enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      OUT
   } state_t;

   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/priority_encoder_param.sv
// Combinational highest-index-wins encoder over a DEPTH-bit vector.
module priority_encoder_param
   import tcam_enc_pkg::*;
#(
   parameter  int DEPTH  = 64,
   localparam int ADDR_W = addr_w(DEPTH)
) (
   input  logic [DEPTH-1:0]  vec,
   output logic [ADDR_W-1:0] idx,
   output logic              any
);

   // Later (higher) indices overwrite earlier ones, so the top set bit wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vec[i]) begin
            idx = ADDR_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcam_match_encoder.sv
// Handshaked TCAM match-line encoder: reports the highest match, or every
// match highest-first when MODE_ALL is set, with hit/multi/last flags.
module tcam_match_encoder
   import tcam_enc_pkg::*;
#(
   parameter  int DEPTH    = 64,
   parameter  bit MODE_ALL = 1'b0,
   localparam int ADDR_W   = addr_w(DEPTH)
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DEPTH-1:0]  in_data,
   input  logic              in_flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_hit,
   output logic              out_multi,
   output logic              out_last
);

   state_t             state;
   logic [DEPTH-1:0]   pending;
   logic               multi;
   logic [ADDR_W-1:0]  enc_idx;
   logic               enc_any;
   logic [DEPTH-1:0]   enc_onehot;
   logic [DEPTH-1:0]   done_onehot;

   priority_encoder_param #(.DEPTH(DEPTH)) u_prio (
      .vec (pending),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign enc_onehot  = DEPTH'(1) << enc_idx;
   assign done_onehot = DEPTH'(1) << out_addr;

   // A flush in IDLE must refuse the vector offered in the same cycle.
   assign in_ready = (state == IDLE) && !in_rst && !in_flush;

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state     <= IDLE;
         pending   <= '0;
         multi     <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_hit   <= 1'b0;
         out_multi <= 1'b0;
         out_last  <= 1'b0;
      end else if (in_flush) begin
         state     <= IDLE;
         pending   <= '0;
         multi     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pending <= in_data;
                  multi   <= |(in_data & (in_data - DEPTH'(1)));
                  state   <= SCAN;
               end
            end
            SCAN: begin
               out_addr  <= enc_idx;
               out_hit   <= enc_any;
               out_multi <= enc_any & multi;
               // An empty vector also ends here: nothing remains after clearing.
               out_last  <= !MODE_ALL || ((pending & ~enc_onehot) == '0);
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     state <= IDLE;
                  end else begin
                     pending <= pending & ~done_onehot;
                     state   <= SCAN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
